// File: rtl/flash_loader.sv
// flash_loader: streams NBYTES bytes out of a SPI flash using the dual-output
// fast-read command. It hands each assembled byte to a write consumer through
// a valid/ready handshake.
//
// Load sequence: 8 command bits, 24 address bits and 8 dummy clocks, then
// two data bits per SPI clock. Each SPI bit takes two system cycles: FCK is
// low in the first cycle and high in the second. When the consumer stalls,
// FCK is held low just before the clock that would complete the next byte,
// so no flash data is lost.
//
// Ports:
//   C25M     system clock; all state changes on its rising edge
//   nRES     asynchronous active-low reset
//   Start    one-cycle load request; accepted only in IDLE or DONE
//   ROMSel   flash image select; becomes flash address bits 14:13
//   nFCS     flash chip select, active-low
//   FCK      SPI clock
//   MOSIout  IO0 output value
//   MOSIOE   IO0 output enable
//   MOSIin   IO0 pin readback; dual-data bit 0
//   MISO     IO1; dual-data bit 1
//   WrData   assembled byte
//   WrAddr   byte offset of WrData within the load
//   WrValid  WrData/WrAddr valid
//   WrReady  consumer accepts the byte
//   Busy     load in progress
//   Done     sticky; set when the final byte has been accepted
module flash_loader #(
  parameter int          NBYTES = 8192,
  parameter logic [7:0]  CMD    = 8'h3B
) (
  input  logic        C25M,
  input  logic        nRES,
  input  logic        Start,
  input  logic [1:0]  ROMSel,
  output logic        nFCS,
  output logic        FCK,
  output logic        MOSIout,
  output logic        MOSIOE,
  input  logic        MOSIin,
  input  logic        MISO,
  output logic [7:0]  WrData,
  output logic [12:0] WrAddr,
  output logic        WrValid,
  input  logic        WrReady,
  output logic        Busy,
  output logic        Done
);

  localparam logic [12:0] LAST_BYTE = 13'(NBYTES - 1);

  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sCmd   = 3'd1,
    sAddr  = 3'd2,
    sDummy = 3'd3,
    sData  = 3'd4,
    sFlush = 3'd5,
    sDone  = 3'd6
  } stateT;

  stateT       state_r;
  logic        ph_r;
  logic [4:0]  bitCnt_r;
  logic [12:0] byteCnt_r;
  logic [5:0]  shiftReg_r;
  logic [1:0]  romSel_r;
  logic        armed_r;
  logic        nFCS_r;
  logic        mosiOut_r;
  logic        mosiOE_r;
  logic [7:0]  wrData_r;
  logic [12:0] wrAddr_r;
  logic        wrValid_r;
  logic        busy_r;
  logic        done_r;

  stateT       nxtState_s;
  logic        nxtPh_s;
  logic [4:0]  nxtBitCnt_s;
  logic        startAcc_s;
  logic        shift_s;
  logic        loadByte_s;
  logic        nxtMosi_s;
  logic        nxtDrive_s;
  logic        nxtSpi_s;

  // Serial bit driven on IO0 for a given bit index of the command or address phase.
  function automatic logic txBit(input stateT st, input logic [4:0] idx,
                                 input logic [1:0] sel);
    logic [23:0] addrWord;
    addrWord = {9'b0, sel, 13'b0};
    case (st)
      sCmd:    txBit = CMD[3'd7 - idx[2:0]];
      sAddr:   txBit = addrWord[5'd23 - idx];
      default: txBit = 1'b0;
    endcase
  endfunction

  // Next-state, phase and bit-counter logic, plus the strobes for the data path.
  always_comb begin
    nxtState_s  = state_r;
    nxtPh_s     = 1'b0;
    nxtBitCnt_s = bitCnt_r;
    startAcc_s  = 1'b0;
    shift_s     = 1'b0;
    loadByte_s  = 1'b0;
    case (state_r)
      sIdle, sDone: begin
        // armed_r blocks a Start seen on the first edge after reset release.
        if (Start && armed_r) begin
          startAcc_s  = 1'b1;
          nxtState_s  = sCmd;
          nxtBitCnt_s = 5'd0;
        end else begin
          nxtState_s  = state_r;
        end
      end
      sCmd, sAddr, sDummy: begin
        nxtPh_s = ~ph_r;
        if (ph_r) begin
          if ((state_r == sCmd   && bitCnt_r == 5'd7)  ||
              (state_r == sAddr  && bitCnt_r == 5'd23) ||
              (state_r == sDummy && bitCnt_r == 5'd7)) begin
            nxtBitCnt_s = 5'd0;
            case (state_r)
              sCmd:    nxtState_s = sAddr;
              sAddr:   nxtState_s = sDummy;
              default: nxtState_s = sData;
            endcase
          end else begin
            nxtBitCnt_s = bitCnt_r + 5'd1;
          end
        end else begin
          nxtBitCnt_s = bitCnt_r;
        end
      end
      sData: begin
        if (!ph_r) begin
          // Hold FCK low ahead of the byte-completing clock while the previous
          // byte is still waiting for the consumer.
          if (bitCnt_r == 5'd3 && wrValid_r && !WrReady) begin
            nxtPh_s = 1'b0;
          end else begin
            nxtPh_s = 1'b1;
          end
        end else begin
          shift_s = 1'b1;
          nxtPh_s = 1'b0;
          if (bitCnt_r == 5'd3) begin
            loadByte_s  = 1'b1;
            nxtBitCnt_s = 5'd0;
            if (byteCnt_r == LAST_BYTE) begin
              nxtState_s = sFlush;
            end else begin
              nxtState_s = sData;
            end
          end else begin
            nxtBitCnt_s = bitCnt_r + 5'd1;
          end
        end
      end
      sFlush: begin
        if (wrValid_r && WrReady) begin
          nxtState_s = sDone;
        end else begin
          nxtState_s = sFlush;
        end
      end
      default: begin
        nxtState_s = sIdle;
      end
    endcase
  end

  // Next values of the registered pin outputs, decoded from the next state.
  always_comb begin
    nxtSpi_s   = (nxtState_s == sCmd) || (nxtState_s == sAddr) ||
                 (nxtState_s == sDummy) || (nxtState_s == sData);
    nxtDrive_s = (nxtState_s == sCmd) || (nxtState_s == sAddr);
    nxtMosi_s  = mosiOut_r;
    if (nxtDrive_s) begin
      // A new bit is presented only at the start of the FCK-low half.
      if (!nxtPh_s) begin
        nxtMosi_s = txBit(nxtState_s, nxtBitCnt_s,
                          startAcc_s ? ROMSel : romSel_r);
      end else begin
        nxtMosi_s = mosiOut_r;
      end
    end else begin
      nxtMosi_s = 1'b0;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge C25M or negedge nRES) begin
    if (!nRES) begin
      state_r    <= sIdle;
      ph_r       <= 1'b0;
      bitCnt_r   <= 5'd0;
      byteCnt_r  <= 13'd0;
      shiftReg_r <= 6'd0;
      romSel_r   <= 2'd0;
      armed_r    <= 1'b0;
      nFCS_r     <= 1'b1;
      mosiOut_r  <= 1'b0;
      mosiOE_r   <= 1'b0;
      wrData_r   <= 8'd0;
      wrAddr_r   <= 13'd0;
      wrValid_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      armed_r   <= 1'b1;
      state_r   <= nxtState_s;
      ph_r      <= nxtPh_s;
      bitCnt_r  <= nxtBitCnt_s;
      nFCS_r    <= ~nxtSpi_s;
      mosiOut_r <= nxtMosi_s;
      mosiOE_r  <= nxtDrive_s;
      busy_r    <= (nxtState_s != sIdle) && (nxtState_s != sDone);
      done_r    <= (nxtState_s == sDone);
      if (startAcc_s) begin
        romSel_r  <= ROMSel;
        byteCnt_r <= 13'd0;
      end
      if (shift_s) begin
        shiftReg_r <= {shiftReg_r[3:0], MISO, MOSIin};
      end
      if (loadByte_s) begin
        wrData_r  <= {shiftReg_r, MISO, MOSIin};
        wrAddr_r  <= byteCnt_r;
        wrValid_r <= 1'b1;
        // The counter stops at the last offset instead of wrapping.
        if (byteCnt_r != LAST_BYTE) begin
          byteCnt_r <= byteCnt_r + 13'd1;
        end
      end else if (WrReady) begin
        wrValid_r <= 1'b0;
      end
    end
  end

  assign nFCS    = nFCS_r;
  assign FCK     = ph_r;
  assign MOSIout = mosiOut_r;
  assign MOSIOE  = mosiOE_r;
  assign WrData  = wrData_r;
  assign WrAddr  = wrAddr_r;
  assign WrValid = wrValid_r;
  assign Busy    = busy_r;
  assign Done    = done_r;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader. A small flash model captures the
// command/address bits and returns byte i = i[7:0] on the dual data lines.
// A write monitor checks every accepted byte against the expected
// offset and value.
module tb_flash_loader;

  localparam int N = 512;

  logic        C25M;
  logic        nRES;
  logic        Start;
  logic [1:0]  ROMSel;
  logic        nFCS;
  logic        FCK;
  logic        MOSIout;
  logic        MOSIOE;
  logic        MOSIin;
  logic        MISO;
  logic [7:0]  WrData;
  logic [12:0] WrAddr;
  logic        WrValid;
  logic        WrReady;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;
  int expAddr = 0;
  int xferTotal = 0;
  int fcnt = 0;
  logic [31:0] capWord = 32'd0;

  flash_loader #(.NBYTES(N), .CMD(8'h3B)) dut (
    .C25M(C25M), .nRES(nRES), .Start(Start), .ROMSel(ROMSel),
    .nFCS(nFCS), .FCK(FCK), .MOSIout(MOSIout), .MOSIOE(MOSIOE),
    .MOSIin(MOSIin), .MISO(MISO), .WrData(WrData), .WrAddr(WrAddr),
    .WrValid(WrValid), .WrReady(WrReady), .Busy(Busy), .Done(Done)
  );

  initial C25M = 1'b0;
  always #20 C25M = ~C25M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C25M);
    #1;
  endtask

  // Flash model: count SPI clocks per select, capture 32 cmd/addr bits,
  // then present data pairs (IO1 = odd bit, IO0 = even bit) MSB first.
  initial begin
    MISO = 1'b0;
    MOSIin = 1'b0;
  end
  always @(posedge FCK or posedge nFCS) begin
    if (nFCS) begin
      fcnt = 0;
      capWord = 32'd0;
    end else begin
      if (fcnt < 32) begin
        capWord = {capWord[30:0], MOSIout};
      end else if (fcnt >= 40) begin
        int j;
        int p;
        logic [7:0] v;
        j = fcnt - 40;
        p = j % 4;
        v = 8'(j / 4);
        MISO = v[7 - 2 * p];
        MOSIin = v[6 - 2 * p];
      end
      fcnt++;
    end
  end

  // Write monitor: every accepted byte must carry the next offset and value.
  always @(negedge C25M) begin
    if (!Busy) begin
      expAddr = 0;
    end else if (WrValid && WrReady) begin
      chk("wrAddr", 32'(WrAddr), 32'(expAddr));
      chk("wrData", 32'(WrData), 32'(expAddr & 255));
      expAddr++;
      xferTotal++;
    end
  end

  initial begin
    int n;
    int base;
    logic sawFck;
    logic sawValid;
    nRES = 1'b0;
    Start = 1'b0;
    ROMSel = 2'b00;
    WrReady = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst nFCS", 32'(nFCS), 32'd1);
    chk("rst FCK", 32'(FCK), 32'd0);
    chk("rst MOSIout", 32'(MOSIout), 32'd0);
    chk("rst MOSIOE", 32'(MOSIOE), 32'd0);
    chk("rst WrValid", 32'(WrValid), 32'd0);
    chk("rst WrData", 32'(WrData), 32'd0);
    chk("rst WrAddr", 32'(WrAddr), 32'd0);
    chk("rst Busy", 32'(Busy), 32'd0);
    chk("rst Done", 32'(Done), 32'd0);

    // Start during reset and on the release edge is ignored
    Start = 1'b1;
    tick();
    chk("startInRst Busy", 32'(Busy), 32'd0);
    nRES = 1'b1;
    tick();
    chk("startOnRelease Busy", 32'(Busy), 32'd0);
    chk("startOnRelease nFCS", 32'(nFCS), 32'd1);
    Start = 1'b0;
    tick();

    // Load 1: ROMSel=11, stray Starts, backpressure at byte 5
    base = xferTotal;
    ROMSel = 2'b11;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("L1 nFCS", 32'(nFCS), 32'd0);
    chk("L1 Busy", 32'(Busy), 32'd1);
    chk("L1 MOSIOE", 32'(MOSIOE), 32'd1);
    chk("L1 FCK ph0", 32'(FCK), 32'd0);
    chk("L1 cmd bit7", 32'(MOSIout), 32'd0);
    tick();
    chk("L1 FCK ph1", 32'(FCK), 32'd1);
    repeat (20) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (60) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!(WrValid && WrAddr == 13'd5) && n < 2000) begin
      tick();
      n++;
    end
    chk("L1 reach byte5", 32'(n < 2000), 32'd1);
    chk("L1 cmd+addr", capWord, 32'h3B006000);
    chk("L1 MOSIOE data", 32'(MOSIOE), 32'd0);
    WrReady = 1'b0;
    sawFck = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i >= 20 && FCK) sawFck = 1'b1;
    end
    chk("stall FCK quiet", 32'(sawFck), 32'd0);
    chk("stall WrValid", 32'(WrValid), 32'd1);
    chk("stall WrData", 32'(WrData), 32'd5);
    chk("stall WrAddr", 32'(WrAddr), 32'd5);
    chk("stall nFCS", 32'(nFCS), 32'd0);
    WrReady = 1'b1;
    n = 0;
    while (!(WrValid && WrAddr == 13'd6) && n < 20) begin
      tick();
      n++;
    end
    chk("byte6 latency", 32'(n <= 8), 32'd1);
    n = 0;
    while (!Done && n < 8 * N + 500) begin
      tick();
      n++;
    end
    chk("L1 Done", 32'(Done), 32'd1);
    chk("L1 Busy end", 32'(Busy), 32'd0);
    chk("L1 nFCS end", 32'(nFCS), 32'd1);
    chk("L1 byte count", 32'(xferTotal - base), 32'(N));

    // Load 2: restart from DONE, exact timing with WrReady high
    base = xferTotal;
    ROMSel = 2'b10;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("L2 Done cleared", 32'(Done), 32'd0);
    chk("L2 Busy", 32'(Busy), 32'd1);
    n = 0;
    while (!(WrValid && WrAddr == 13'(N - 1)) && n < 80 + 8 * N + 50) begin
      tick();
      n++;
      if (n == 60) chk("L2 MOSIOE addr", 32'(MOSIOE), 32'd1);
      if (n == 70) chk("L2 MOSIOE dummy", 32'(MOSIOE), 32'd0);
      if (n == 100) chk("L2 cmd+addr", capWord, 32'h3B004000);
    end
    chk("L2 last byte cycles", 32'(n), 32'(80 + 8 * N));
    chk("L2 flush nFCS", 32'(nFCS), 32'd1);
    chk("L2 flush FCK", 32'(FCK), 32'd0);
    chk("L2 flush Busy", 32'(Busy), 32'd1);
    tick();
    chk("L2 Done", 32'(Done), 32'd1);
    chk("L2 Busy end", 32'(Busy), 32'd0);
    chk("L2 WrValid end", 32'(WrValid), 32'd0);
    chk("L2 byte count", 32'(xferTotal - base), 32'(N));

    // Load 3: reset during byte 300, then a fresh load from offset 0
    ROMSel = 2'b00;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!(WrValid && WrAddr == 13'd300) && n < 8 * N) begin
      tick();
      n++;
    end
    chk("L3 reach byte300", 32'(n < 8 * N), 32'd1);
    tick();
    nRES = 1'b0;
    #1;
    chk("abort nFCS", 32'(nFCS), 32'd1);
    chk("abort WrValid", 32'(WrValid), 32'd0);
    chk("abort Busy", 32'(Busy), 32'd0);
    chk("abort FCK", 32'(FCK), 32'd0);
    tick();
    nRES = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (WrValid) sawValid = 1'b1;
    end
    chk("no WrValid after abort", 32'(sawValid), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!WrValid && n < 200) begin
      tick();
      n++;
    end
    chk("restart WrValid", 32'(WrValid), 32'd1);
    chk("restart WrAddr", 32'(WrAddr), 32'd0);
    chk("restart WrData", 32'(WrData), 32'd0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
